// File: rtl/fifo_stream_reader_pkg.sv
// Shared merger-tree definitions used by the FIFO read-side engine.
//   REC_W_DEFAULT : default record width
//   TERMINAL_REC  : the all-zero record that ends a sorted run
//   rd_state_e    : reader state encoding
package fifo_stream_reader_pkg;

  localparam int REC_W_DEFAULT = 128;

  localparam logic [REC_W_DEFAULT-1:0] TERMINAL_REC = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry (head + skid) data/last buffer.
//   i_clk, i_rst   : clock, async active-high reset
//   i_push, i_data, i_last : write one entry
//   i_pop          : retire the head entry
//   o_occ          : number of held entries (0..2)
//   o_data, o_last : head entry
module stream_skid2
  import fifo_stream_reader_pkg::*;
#(
  parameter int P_WIDTH = REC_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [P_WIDTH-1:0] i_data,
  input  logic               i_last,
  input  logic               i_pop,
  output logic [1:0]         o_occ,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_last
);

  logic [P_WIDTH-1:0] head_data_q, head_data_d;
  logic [P_WIDTH-1:0] skid_data_q, skid_data_d;
  logic               head_last_q, head_last_d;
  logic               skid_last_q, skid_last_d;
  logic [1:0]         occ_q, occ_d;

  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    occ_d       = occ_q;
    unique case ({i_push, i_pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_data_d = i_data;
          head_last_d = i_last;
          occ_d       = 2'd1;
        end else if (occ_q == 2'd1) begin
          skid_data_d = i_data;
          skid_last_d = i_last;
          occ_d       = 2'd2;
        end
      end
      2'b01: begin
        if (occ_q == 2'd1) begin
          occ_d = 2'd0;
        end else if (occ_q == 2'd2) begin
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
          occ_d       = 2'd1;
        end
      end
      2'b11: begin
        // Full buffer never sees a push from the reader; the occ2 arm just
        // keeps the buffer coherent if a caller does it anyway.
        if (occ_q == 2'd2) begin
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
          skid_data_d = i_data;
          skid_last_d = i_last;
        end else begin
          head_data_d = i_data;
          head_last_d = i_last;
          occ_d       = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      occ_q       <= occ_d;
    end
  end

  assign o_occ  = occ_q;
  assign o_data = head_data_q;
  assign o_last = head_last_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side engine for shift-register FIFOs: drains sorted records into a
// registered valid/ready stream, stops after the all-zero terminal record,
// reports completion and counts delivered non-terminal records.
//   i_clk, i_rst             : clock, async active-high reset
//   i_fifo_data/i_fifo_empty : FIFO head word and empty flag
//   o_fifo_deq               : pop request (takes effect at the clock edge)
//   o_data/o_valid/i_ready   : output stream
//   o_last                   : head is the terminal record
//   o_done                   : terminal record has been transferred
//   o_count                  : saturating count of non-terminal transfers
//   i_restart                : rearm after completion
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int P_WIDTH = REC_W_DEFAULT,
  parameter int P_CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [P_WIDTH-1:0] i_fifo_data,
  input  logic               i_fifo_empty,
  output logic               o_fifo_deq,
  output logic [P_WIDTH-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_done,
  output logic [P_CNT_W-1:0] o_count,
  input  logic               i_restart
);

  localparam logic [P_WIDTH-1:0] TERM_W  = P_WIDTH'(TERMINAL_REC);
  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

  rd_state_e          state_q, state_d;
  logic [P_CNT_W-1:0] count_q, count_d;
  logic [1:0]         occ;
  logic               head_last;
  logic               in_last;
  logic               xfer;

  // Pop depends only on registered state and the empty flag, so there is no
  // combinational path from i_ready back to the FIFO.
  assign o_fifo_deq = !i_rst && (state_q == RUN) && !i_fifo_empty && (occ != 2'd2);
  assign in_last    = (i_fifo_data == TERM_W);
  assign o_valid    = (occ != 2'd0) && (state_q != DONE);
  assign o_last     = o_valid && head_last;
  assign xfer       = o_valid && i_ready;
  assign o_done     = (state_q == DONE);
  assign o_count    = count_q;

  stream_skid2 #(.P_WIDTH(P_WIDTH)) u_buf (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (o_fifo_deq),
    .i_data (i_fifo_data),
    .i_last (in_last),
    .i_pop  (xfer),
    .o_occ  (occ),
    .o_data (o_data),
    .o_last (head_last)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      RUN:   if (o_fifo_deq && in_last) state_d = DRAIN;
      DRAIN: if (xfer && o_last)        state_d = DONE;
      DONE: begin
        if (i_restart) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
    if (xfer && !o_last && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  localparam int W = 32;
  localparam int S_RUN = 0, S_DRAIN = 1, S_DONE = 2;

  logic         i_clk = 1'b0;
  logic         i_rst, i_fifo_empty, i_ready, i_restart;
  logic [W-1:0] i_fifo_data;
  logic         o_fifo_deq, o_valid, o_last, o_done;
  logic [W-1:0] o_data;
  logic [31:0]  o_count;
  logic         s_deq, s_valid, s_last, s_done;
  logic [W-1:0] s_data;
  logic [2:0]   s_count;

  always #5 i_clk = ~i_clk;

  fifo_stream_reader #(.P_WIDTH(W), .P_CNT_W(32)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
    .o_fifo_deq(o_fifo_deq), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_done(o_done), .o_count(o_count), .i_restart(i_restart));

  // Narrow-counter copy on the same stimulus, for saturation.
  fifo_stream_reader #(.P_WIDTH(W), .P_CNT_W(3)) u_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
    .o_fifo_deq(s_deq), .o_data(s_data), .o_valid(s_valid), .i_ready(i_ready),
    .o_last(s_last), .o_done(s_done), .o_count(s_count), .i_restart(i_restart));

  int total = 0, bad = 0;
  logic [W-1:0] fq[$];     // FIFO contents
  logic [W-1:0] mb[$];     // records accepted by the reader, not yet delivered
  logic [W-1:0] outq[$];   // records observed leaving the DUT
  logic [W-1:0] expq[$];
  int m_state = S_RUN, m_cnt = 0;
  int ndeq = 0, empty_deq = 0, cyc = 0;
  bit gap = 0;

  // Expected {deq, valid, last, done} from the model.
  function automatic logic [3:0] exp_flags();
    logic v, d, l;
    v = (mb.size() > 0) && (m_state != S_DONE);
    d = !i_rst && (m_state == S_RUN) && !i_fifo_empty && (mb.size() < 2);
    l = 1'b0;
    if (v) l = (mb[0] == '0);
    return {d, v, l, m_state == S_DONE};
  endfunction

  function automatic int exp_sat();
    return (m_cnt > 7) ? 7 : m_cnt;
  endfunction

  function automatic logic [W-1:0] rnd_rec();
    logic [W-1:0] w;
    w = W'($urandom);
    if (w == '0) w = 1;
    return w;
  endfunction

  task automatic prep();
    i_fifo_empty = gap || (fq.size() == 0);
    i_fifo_data  = i_fifo_empty ? W'($urandom) : fq[0];
    #1;
  endtask

  task automatic tick();
    logic [3:0]   ef;
    logic [W-1:0] hw, w;
    bit xf, dd;
    ef = exp_flags();
    xf = ef[2] && i_ready;
    dd = o_fifo_deq;
    hw = i_fifo_data;
    if (dd) ndeq++;
    if (dd && i_fifo_empty) empty_deq++;
    if (o_valid && i_ready) outq.push_back(o_data);
    @(posedge i_clk);
    if (dd && !i_fifo_empty && fq.size() > 0) fq.delete(0);
    if (!i_rst) begin
      if (m_state == S_DONE) begin
        if (i_restart) begin m_state = S_RUN; m_cnt = 0; end
      end else begin
        if (xf) begin
          w = mb.pop_front();
          if (w == '0) m_state = S_DONE; else m_cnt++;
        end
        if (ef[3]) begin
          mb.push_back(hw);
          if (hw == '0) m_state = S_DRAIN;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic pulse_restart();
    i_restart = 1'b1; prep(); tick(); i_restart = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ready = 1'b0; i_restart = 1'b0; gap = 0;
    prep();
    total++;
    if ({o_fifo_deq, o_valid, o_last, o_done} !== 4'b0 || o_data !== '0 || o_count !== '0) begin
      bad++; $display("FAIL reset_state: deq=%b v=%b l=%b d=%b data=%h cnt=%0d want all 0",
                      o_fifo_deq, o_valid, o_last, o_done, o_data, o_count);
    end
    @(posedge i_clk); #1; i_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      prep();
      total++;
      if ({o_fifo_deq, o_valid, o_count} !== {2'b00, 32'd0}) begin
        bad++; $display("FAIL idle c%0d: deq=%b v=%b cnt=%0d want 0 0 0", c, o_fifo_deq, o_valid, o_count);
      end
      tick();
    end
    fq = '{32'd11, 32'd12, 32'd13};
    for (int c = 0; c < 3; c++) begin prep(); tick(); end
    prep();
    total++;
    if (o_valid !== 1'b1 || o_data !== 32'd11) begin
      bad++; $display("FAIL pre_reset: v=%b data=%0d want 1 11", o_valid, o_data);
    end
    i_rst = 1'b1; #1;
    mb.delete(); m_state = S_RUN; m_cnt = 0;
    total++;
    if ({o_fifo_deq, o_valid, o_last, o_done} !== 4'b0 || o_data !== '0 || o_count !== '0) begin
      bad++; $display("FAIL async_reset: deq=%b v=%b data=%h cnt=%0d want 0 0 0 0",
                      o_fifo_deq, o_valid, o_data, o_count);
    end
    tick();
    total++;
    if (fq.size() != 1) begin
      bad++; $display("FAIL reset_fifo_kept: fifo size %0d want 1", fq.size());
    end
    i_rst = 1'b0; fq.delete();
  endtask

  task automatic test_streaming();
    int first, lastc;
    fq = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
    expq = fq; outq.delete(); ndeq = 0; i_ready = 1'b1; first = -1; lastc = -1;
    for (int c = 0; c < 8; c++) begin
      prep();
      total++;
      if ({o_fifo_deq, o_valid, o_last, o_done} !== exp_flags()) begin
        bad++; $display("FAIL stream_flags c%0d: got %b want %b", c, {o_fifo_deq, o_valid, o_last, o_done}, exp_flags());
      end
      if (mb.size() > 0) begin
        total++;
        if (o_data !== mb[0]) begin bad++; $display("FAIL stream_data c%0d: got %0d want %0d", c, o_data, mb[0]); end
      end
      if (o_valid) begin if (first < 0) first = c; lastc = c; end
      tick();
    end
    prep();
    total++;
    if (ndeq != 5 || lastc - first != 4 || o_done !== 1'b1 || o_count !== 32'd4) begin
      bad++; $display("FAIL stream_summary: deq=%0d span=%0d done=%b cnt=%0d want 5 4 1 4",
                      ndeq, lastc - first, o_done, o_count);
    end
    total++;
    if (outq != expq) begin bad++; $display("FAIL stream_order: got %p want %p", outq, expq); end
    pulse_restart(); prep();
    total++;
    if (o_done !== 1'b0 || o_count !== '0 || s_count !== '0) begin
      bad++; $display("FAIL restart_clear: done=%b cnt=%0d scnt=%0d want 0 0 0", o_done, o_count, s_count);
    end
  endtask

  task automatic test_backpressure();
    fq = '{32'd1, 32'd2, 32'd3, 32'd0};
    expq = fq; outq.delete(); ndeq = 0; i_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin prep(); tick(); end
    prep();
    total++;
    if (ndeq != 2 || o_valid !== 1'b1 || o_data !== 32'd1) begin
      bad++; $display("FAIL bp_hold: deq=%0d v=%b data=%0d want 2 1 1", ndeq, o_valid, o_data);
    end
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      prep();
      total++;
      if ({o_fifo_deq, o_valid, o_last, o_done} !== exp_flags() || (mb.size() > 0 && o_data !== mb[0])) begin
        bad++; $display("FAIL bp_flow c%0d: flags %b data %0d", c, {o_fifo_deq, o_valid, o_last, o_done}, o_data);
      end
      tick();
    end
    total++;
    if (outq != expq) begin bad++; $display("FAIL bp_order: got %p want %p", outq, expq); end
    pulse_restart();
  endtask

  task automatic test_terminal_stop();
    fq = '{32'd9, 32'd0, 32'd4, 32'd4}; outq.delete(); i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin prep(); tick(); end
    prep();
    total++;
    if (fq.size() != 2 || o_done !== 1'b1 || o_count !== 32'd1) begin
      bad++; $display("FAIL term_stop: fifo=%0d done=%b cnt=%0d want 2 1 1", fq.size(), o_done, o_count);
    end
    pulse_restart();
    for (int c = 0; c < 6; c++) begin prep(); tick(); end
    prep();
    total++;
    if (fq.size() != 0 || o_done !== 1'b0 || o_count !== 32'd2 || o_count !== 32'(m_cnt)) begin
      bad++; $display("FAIL term_rearm: fifo=%0d done=%b cnt=%0d want 0 0 2", fq.size(), o_done, o_count);
    end
    fq.push_back('0);
    for (int c = 0; c < 4; c++) begin prep(); tick(); end
    pulse_restart();
  endtask

  task automatic test_gaps();
    expq.delete(); outq.delete(); empty_deq = 0; i_ready = 1'b1;
    for (int i = 0; i < 10; i++) expq.push_back(rnd_rec());
    fq = expq;
    for (int c = 0; c < 30; c++) begin
      gap = (c % 2 == 0);
      prep();
      total++;
      if ({o_fifo_deq, o_valid, o_last, o_done} !== exp_flags() || (mb.size() > 0 && o_data !== mb[0])) begin
        bad++; $display("FAIL gap_flow c%0d: flags %b want %b", c, {o_fifo_deq, o_valid, o_last, o_done}, exp_flags());
      end
      tick();
    end
    gap = 0;
    total++;
    if (outq != expq || empty_deq != 0) begin
      bad++; $display("FAIL gap_order: n=%0d want 10, deq_while_empty=%0d want 0", outq.size(), empty_deq);
    end
    pulse_restart(); prep();
    total++;
    if (o_count !== 32'd10 || s_count !== 3'd7 || o_done !== 1'b0) begin
      bad++; $display("FAIL gap_sat: cnt=%0d scnt=%0d done=%b want 10 7 0", o_count, s_count, o_done);
    end
    fq.push_back('0);
    for (int c = 0; c < 4; c++) begin prep(); tick(); end
    pulse_restart();
  endtask

  task automatic test_random();
    int extra, lim;
    for (int r = 0; r < 4; r++) begin
      expq.delete(); outq.delete(); fq.delete();
      for (int i = 0; i < $urandom_range(30, 3); i++) expq.push_back(rnd_rec());
      expq.push_back('0);
      fq = expq;
      extra = $urandom_range(3, 0);
      for (int i = 0; i < extra; i++) fq.push_back(rnd_rec());
      lim = 0;
      while (m_state != S_DONE && lim < 400) begin
        gap = ($urandom_range(3, 0) == 0);
        i_ready = ($urandom_range(2, 0) != 0);
        prep();
        total++;
        if ({o_fifo_deq, o_valid, o_last, o_done} !== exp_flags() || (mb.size() > 0 && o_data !== mb[0])
            || o_count !== 32'(m_cnt) || s_count !== 3'(exp_sat())) begin
          bad++; $display("FAIL rand r%0d cyc%0d: flags %b want %b data %0d cnt %0d/%0d scnt %0d/%0d",
                          r, lim, {o_fifo_deq, o_valid, o_last, o_done}, exp_flags(), o_data,
                          o_count, m_cnt, s_count, exp_sat());
        end
        tick(); lim++;
      end
      gap = 0;
      for (int c = 0; c < 2; c++) begin prep(); tick(); end
      prep();
      total++;
      if (outq != expq || fq.size() != extra || o_done !== 1'b1) begin
        bad++; $display("FAIL rand_end r%0d: out=%0d want %0d, left=%0d want %0d, done=%b",
                        r, outq.size(), expq.size(), fq.size(), extra, o_done);
      end
      fq.delete();
      pulse_restart();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_terminal_stop();
    test_gaps();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side engine for the team's shift-register FIFOs (IFIFO16/IFIFO32 style: head word visible combinationally, pop on `deq`).
- Drains sorted records from one FIFO and presents them on a registered valid/ready stream feeding a merger-tree leaf.
- Detects the all-zero terminal record, stops popping after it, and reports completion.
- Counts records delivered.

Parameters:
- P_WIDTH, 128, record width in bits.
- P_CNT_W, 32, width of delivered-record counter.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_fifo_data  in  P_WIDTH  FIFO head word; valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_deq  out  1  pop request to FIFO; the pop takes effect at the clock edge.
- o_data  out  P_WIDTH  output record (head register).
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts; transfer = o_valid & i_ready.
- o_last  out  1  o_data is the terminal record; qualified by o_valid.
- o_done  out  1  terminal record has been transferred.
- o_count  out  P_CNT_W  non-terminal records transferred, saturating.
- i_restart  in  1  single-cycle pulse; rearms the reader after completion.

Behaviour:
- Clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_valid=0, o_data=0, o_last=0, o_done=0, o_count=0, occupancy=0, state=RUN. o_fifo_deq=0 while i_rst=1.
- Buffer: two entries, head and skid, with occupancy occ ∈ {0,1,2}.
  - o_valid = (occ≠0). o_data and o_last come from head.
- Pop rule: o_fifo_deq = (state==RUN) & !i_fifo_empty & (occ<2).
  - The rule depends only on registered state and i_fifo_empty. There is no combinational path from i_ready to o_fifo_deq.
  - Never pop when empty (no underrun).
- Push is the cycle in which o_fifo_deq=1; the word captured is i_fifo_data. Pop is a transfer (o_valid & i_ready).
  - push only: occ0→head=in, occ1. occ1→skid=in, occ2.
  - pop only: occ1→occ0. occ2→head=skid, occ1.
  - push and pop: occ1→head=in, occ1. occ2 cannot push.
- Throughput is 1 record/cycle in steady state with i_ready=1.
- Latency: a word at the FIFO head at edge N appears on o_data with o_valid=1 after edge N.
- Terminal: a word equal to all zeros (TERMINAL_REC).
  - The captured word's last flag = (in==0). It is stored per entry and travels with the data.
- FSM:
  - RUN: when a push captures the terminal word → DRAIN. From the same edge, o_fifo_deq=0.
  - DRAIN: no further pops. When the terminal entry transfers → DONE, and o_done=1 from the next cycle.
  - DONE: o_valid=0 and o_fifo_deq=0. i_restart=1 → RUN; o_done←0 and o_count←0 at that edge.
  - i_restart is ignored in RUN and DRAIN.
- o_count increments on each transfer with o_last=0. It holds at 2^P_CNT_W−1 (no wrap). The terminal transfer is not counted.
- Words already in the FIFO behind the terminal are left untouched until restart.
- Output stability: while o_valid=1 and i_ready=0, o_data and o_last hold.
- Reset asserted mid-stream: the buffer contents are discarded asynchronously, outputs return to reset values, and state returns to RUN. The FIFO's own contents are not affected.

Decomposition:
- Shared package (merger-tree common), holding:
  - TERMINAL_REC = {P_WIDTH{1'b0}};
  - reader state encoding RUN=2'd0, DRAIN=2'd1, DONE=2'd2;
  - the default record width 128.
- One sub-module: stream_skid2.
  - Two-entry data+last buffer with occupancy output, push/pop inputs and async reset.
  - fifo_stream_reader wraps it with the FSM, pop logic and counter.

Test Plan:
- Reset then idle: i_fifo_empty=1 → o_fifo_deq=0, o_valid=0, o_count=0 for 10 cycles. Assert i_rst mid-cycle → outputs clear immediately.
- Streaming: FIFO preloaded with 5,6,7,8,0 and i_ready=1 → o_data 5,6,7,8,0 on consecutive cycles, o_last only on 0, o_done=1 the cycle after, o_count=4, exactly 5 deq pulses.
- Backpressure: i_ready=0 for 6 cycles with records 1,2,3 available → exactly 2 deq pulses, o_data holds 1. On i_ready=1 → 1,2,3 in order, no loss or duplication.
- Terminal stop: FIFO holds 9,0,4,4 → deq stops after 0, the 4s remain in the FIFO. After i_restart → the 4s are read, o_count restarts from 0.
- Empty gaps: the FIFO alternates empty/non-empty every cycle while 10 records trickle in → no deq while empty, 10 records out in order, o_count=10.
- Saturation: P_CNT_W=3, 9 non-terminal records → o_count stops at 7. i_restart pulsed in RUN is ignored.
